// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: the fetch (F) and data (D) requester ports,
// the shared 16-bit memory port and the busy indication.
interface mem_arbiter_if;
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_ack;
  logic [15:0] f_rdata;
  logic        f_err;

  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        d_err;

  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  logic        busy;

  // Arbiter side.
  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output f_ack, f_rdata, f_err, d_ack, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Requester / memory side.
  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  f_ack, f_rdata, f_err, d_ack, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 16-bit memory port between the fetch (F) and
// data (D) requesters. Ties are broken round-robin, the memory request is
// held until mem_ready, and a watchdog aborts accesses that never complete.
//
// state | meaning
// IDLE  | no access; grant on any request
// BUSY  | access on the memory port, waiting for mem_ready or the watchdog
// ACK   | one-cycle ack/err pulse to the owner, no grant
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic       PORT_F   = 1'b0;
  localparam logic       PORT_D   = 1'b1;
  // Counter value on the last BUSY cycle the watchdog allows.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic        owner_q;
  logic        last_q;
  logic [7:0]  cnt_q;
  logic        mem_en_q;
  logic        mem_we_q;
  logic [15:0] mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic        f_ack_q;
  logic        f_err_q;
  logic [15:0] f_rdata_q;
  logic        d_ack_q;
  logic        d_err_q;
  logic [15:0] d_rdata_q;
  logic        busy_q;

  logic        req_any;
  logic        grant_d;

  // Choose the port a grant in IDLE would go to: the lone requester, or on a tie the one not served last.
  always_comb begin
    req_any = bus.f_req | bus.d_req;
    grant_d = PORT_F;
    if (bus.f_req && bus.d_req) begin
      grant_d = ~last_q;
    end else if (bus.d_req) begin
      grant_d = PORT_D;
    end
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= PORT_F;
      last_q      <= PORT_D;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      f_ack_q     <= 1'b0;
      f_err_q     <= 1'b0;
      f_rdata_q   <= '0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_any) begin
            state_q  <= BUSY;
            busy_q   <= 1'b1;
            owner_q  <= grant_d;
            last_q   <= grant_d;
            cnt_q    <= '0;
            mem_en_q <= 1'b1;
            if (grant_d == PORT_D) begin
              mem_addr_q  <= bus.d_addr;
              mem_we_q    <= bus.d_we;
              mem_wdata_q <= bus.d_wdata;
            end else begin
              // Fetches are always reads; mem_wdata is don't-care and left alone.
              mem_addr_q <= bus.f_addr;
              mem_we_q   <= 1'b0;
            end
          end
        end
        BUSY: begin
          // mem_ready takes priority over the watchdog on the same cycle.
          if (bus.mem_ready || (cnt_q == CNT_LAST)) begin
            state_q  <= ACK;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (owner_q == PORT_D) begin
              d_ack_q <= 1'b1;
              d_err_q <= ~bus.mem_ready;
              if (!bus.mem_ready) begin
                d_rdata_q <= '0;
              end else if (!mem_we_q) begin
                d_rdata_q <= bus.mem_rdata;
              end
            end else begin
              f_ack_q   <= 1'b1;
              f_err_q   <= ~bus.mem_ready;
              f_rdata_q <= bus.mem_ready ? bus.mem_rdata : 16'h0000;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ACK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          f_ack_q <= 1'b0;
          f_err_q <= 1'b0;
          d_ack_q <= 1'b0;
          d_err_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.f_ack     = f_ack_q;
  assign bus.f_err     = f_err_q;
  assign bus.f_rdata   = f_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner-case
// sequences, and a randomized run against a transaction-level model.
module tb_mem_arbiter;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        port_d;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mdata;
    int          waits;
    int          exp_lat;
    logic        exp_err;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One isolated access; memory raises mem_ready on BUSY cycle waits+1.
  task automatic do_access(input vec_t v, input int idx);
    int lat;
    bit seen;
    if (v.port_d) begin
      bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.f_req = 1'b1; bus.f_addr = v.addr;
    end
    @(negedge clk);
    chk($sformatf("v%0d grant mem_en", idx), bus.mem_en, 1);
    chk($sformatf("v%0d grant mem_addr", idx), bus.mem_addr, v.addr);
    chk($sformatf("v%0d grant mem_we", idx), bus.mem_we, v.port_d & v.we);
    if (v.port_d && v.we) chk($sformatf("v%0d grant mem_wdata", idx), bus.mem_wdata, v.wdata);
    lat = 0;
    seen = 0;
    for (int n = 1; n <= TO + 2 && !seen; n++) begin
      bus.mem_ready = (n == v.waits + 1);
      bus.mem_rdata = bus.mem_ready ? v.mdata : 16'($urandom);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if ((v.port_d ? bus.d_ack : bus.f_ack) === 1'b1) begin
        seen = 1;
        lat = n;
      end else begin
        chk($sformatf("v%0d hold mem_en", idx), bus.mem_en, 1);
        chk($sformatf("v%0d hold mem_addr", idx), bus.mem_addr, v.addr);
        chk($sformatf("v%0d hold mem_we", idx), bus.mem_we, v.port_d & v.we);
        if (v.port_d && v.we) chk($sformatf("v%0d hold mem_wdata", idx), bus.mem_wdata, v.wdata);
      end
    end
    chk($sformatf("v%0d ack latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d err", idx), v.port_d ? bus.d_err : bus.f_err, v.exp_err);
    chk($sformatf("v%0d rdata", idx), v.port_d ? bus.d_rdata : bus.f_rdata, v.exp_rdata);
    chk($sformatf("v%0d other ack", idx), v.port_d ? bus.f_ack : bus.d_ack, 0);
    chk($sformatf("v%0d mem_en dropped", idx), bus.mem_en, 0);
    if (v.port_d) bus.d_req = 1'b0; else bus.f_req = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d ack one cycle", idx), v.port_d ? bus.d_ack : bus.f_ack, 0);
    chk($sformatf("v%0d idle busy", idx), bus.busy, 0);
  endtask

  // Randomized-phase model state
  logic [15:0] mem_arr[16];
  logic [15:0] ref_mem[16];
  logic [15:0] prev_rd[2];
  int          owner, gnt, w, n, done, free_edge, p, last_m, ng;
  logic [15:0] o_addr, o_wd, exp_rd;
  logic        o_we, terr, s_f, s_d, ack_f, ack_d, prev_en;
  logic [15:0] gaddr[4];
  logic [15:0] exp_g;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    //            port  we    addr      wdata     mdata    waits lat err   rdata
    vecs[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h1234,  0,  1, 1'b0, 16'h1234};
    vecs[1] = '{1'b1, 1'b1, 16'h8000, 16'hBEEF, 16'h5555,  2,  3, 1'b0, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 16'h0123, 16'h0000, 16'hA5A5,  0,  1, 1'b0, 16'hA5A5};
    vecs[3] = '{1'b1, 1'b1, 16'h0200, 16'h1111, 16'h6666,  1,  2, 1'b0, 16'hA5A5};
    vecs[4] = '{1'b1, 1'b0, 16'h0300, 16'h0000, 16'h9999, 99, 16, 1'b1, 16'h0000};
    vecs[5] = '{1'b1, 1'b1, 16'h0400, 16'h2222, 16'h9999, 99, 16, 1'b1, 16'h0000};
    vecs[6] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h8888, 16, 16, 1'b1, 16'h0000};
    vecs[7] = '{1'b1, 1'b0, 16'h0301, 16'h0000, 16'hCAFE, 15, 16, 1'b0, 16'hCAFE};
    vecs[8] = '{1'b0, 1'b0, 16'h0044, 16'h0000, 16'h7777,  3,  4, 1'b0, 16'h7777};

    reset = 1'b0;
    bus.f_req = 0; bus.f_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
    bus.d_wdata = 0; bus.mem_rdata = 0; bus.mem_ready = 0;
    #1 reset = 1'b1;
    #2;
    chk("reset mem_en", bus.mem_en, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset acks", {bus.f_ack, bus.d_ack, bus.f_err, bus.d_err}, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) do_access(vecs[i], i);

    // Stray mem_ready in IDLE, then held high through an access and its ACK cycle.
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'h5A5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray idle acks", {bus.f_ack, bus.d_ack}, 0);
      chk("stray idle busy", bus.busy, 0);
      chk("stray idle mem_en", bus.mem_en, 0);
      chk("stray idle f_rdata", bus.f_rdata, vecs[8].exp_rdata);
    end
    bus.f_req = 1'b1; bus.f_addr = 16'h0050; bus.mem_rdata = 16'h0BAD;
    @(negedge clk);
    chk("stray grant mem_en", bus.mem_en, 1);
    chk("stray grant no ack", bus.f_ack, 0);
    @(negedge clk);
    chk("stray access ack", bus.f_ack, 1);
    chk("stray access rdata", bus.f_rdata, 16'h0BAD);
    bus.f_req = 1'b0; bus.mem_rdata = 16'hDEAD;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stray after acks", {bus.f_ack, bus.d_ack}, 0);
      chk("stray after rdata", bus.f_rdata, 16'h0BAD);
      chk("stray after busy", bus.busy, 0);
    end
    bus.mem_ready = 1'b0;

    // Asynchronous reset in the middle of a BUSY access.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0777;
    @(negedge clk);
    chk("midreset grant", bus.mem_en, 1);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midreset mem_en", bus.mem_en, 0);
    chk("midreset busy", bus.busy, 0);
    chk("midreset mem_addr", bus.mem_addr, 0);
    chk("midreset f_rdata", bus.f_rdata, 0);
    chk("midreset d_rdata", bus.d_rdata, 0);
    chk("midreset ack/err", {bus.f_ack, bus.d_ack, bus.f_err, bus.d_err}, 0);
    bus.d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midreset no ack", {bus.f_ack, bus.d_ack}, 0);
    end

    // Round-robin with both requesters always pending; first tie after reset goes to F.
    bus.f_addr = 16'h1000; bus.d_addr = 16'h2000; bus.d_we = 1'b0;
    bus.f_req = 1'b1; bus.d_req = 1'b1; bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) gaddr[i] = 16'h0000;
    ng = 0; prev_en = 1'b0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge clk);
      if (bus.mem_en && !prev_en) begin
        gaddr[ng] = bus.mem_addr;
        ng++;
      end
      prev_en = bus.mem_en;
      bus.f_req = bus.f_ack ? 1'b0 : 1'b1;
      bus.d_req = bus.d_ack ? 1'b0 : 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? bus.f_addr : bus.d_addr;
      chk($sformatf("rr grant %0d", i), gaddr[i], exp_g);
    end
    bus.f_req = 1'b0; bus.d_req = 1'b0;
    repeat (3) @(negedge clk);
    bus.mem_ready = 1'b0;

    // Randomized run against a transaction-level model.
    #1 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_arr[i] = 16'($urandom);
      ref_mem[i] = mem_arr[i];
    end
    owner = -1; gnt = 0; w = 0; last_m = 1; free_edge = 0;
    prev_rd[0] = 16'h0000; prev_rd[1] = 16'h0000;
    o_addr = 0; o_wd = 0; o_we = 0;
    for (int e = 0; e < 3000; e++) begin
      @(negedge clk);
      s_f = bus.f_req; s_d = bus.d_req;
      ack_f = 1'b0; ack_d = 1'b0;
      if (owner < 0) begin
        if (e >= free_edge && (s_f || s_d)) begin
          p = (s_f && s_d) ? (1 - last_m) : (s_d ? 1 : 0);
          last_m = p; owner = p; gnt = e;
          o_addr = (p == 1) ? bus.d_addr : bus.f_addr;
          o_we   = (p == 1) ? bus.d_we : 1'b0;
          o_wd   = bus.d_wdata;
          chk("rnd grant mem_en", bus.mem_en, 1);
          chk("rnd grant mem_addr", bus.mem_addr, o_addr);
          chk("rnd grant mem_we", bus.mem_we, o_we);
          if (o_we) chk("rnd grant mem_wdata", bus.mem_wdata, o_wd);
          w = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3) : $urandom_range(13, 17);
        end else begin
          chk("rnd idle mem_en", bus.mem_en, 0);
          chk("rnd idle busy", bus.busy, 0);
        end
        chk("rnd no ack", {bus.f_ack, bus.d_ack}, 0);
      end else begin
        n = e - gnt;
        done = (w + 1 < TO) ? w + 1 : TO;
        if (n < done) begin
          chk("rnd wait acks", {bus.f_ack, bus.d_ack}, 0);
          chk("rnd wait mem_en", bus.mem_en, 1);
          chk("rnd wait busy", bus.busy, 1);
        end else begin
          terr = (w + 1 > TO);
          exp_rd = terr ? 16'h0000 : (o_we ? prev_rd[owner] : ref_mem[o_addr[3:0]]);
          chk("rnd ack owner", (owner == 1) ? bus.d_ack : bus.f_ack, 1);
          chk("rnd ack other", (owner == 1) ? bus.f_ack : bus.d_ack, 0);
          chk("rnd err", (owner == 1) ? bus.d_err : bus.f_err, terr);
          chk("rnd rdata", (owner == 1) ? bus.d_rdata : bus.f_rdata, exp_rd);
          chk("rnd ack mem_en", bus.mem_en, 0);
          prev_rd[owner] = exp_rd;
          if (!terr && o_we) ref_mem[o_addr[3:0]] = o_wd;
          if (owner == 1) ack_d = 1'b1; else ack_f = 1'b1;
          owner = -1;
          free_edge = e + 2;
        end
      end
      // Memory model: completes on the chosen cycle, otherwise stray ready only when no access is pending.
      if (owner >= 0 && (e + 1 - gnt) == w + 1) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem_arr[bus.mem_addr[3:0]];
        if (bus.mem_we) mem_arr[bus.mem_addr[3:0]] = bus.mem_wdata;
      end else if (owner < 0 && $urandom_range(0, 3) == 0) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'($urandom);
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'($urandom);
      end
      // Requesters: drop at ack, otherwise occasionally raise a new request.
      if (ack_f) begin
        bus.f_req = 1'b0;
      end else if (!bus.f_req && $urandom_range(0, 2) == 0) begin
        bus.f_req = 1'b1;
        bus.f_addr = 16'($urandom);
      end
      if (ack_d) begin
        bus.d_req = 1'b0;
      end else if (!bus.d_req && $urandom_range(0, 2) == 0) begin
        bus.d_req = 1'b1;
        bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = 16'($urandom);
        bus.d_wdata = 16'($urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
